sc_fifo_wr_arb: RTL and testbench

- Round-robin, packet-locked write arbiter that shares one single-clock FIFO write port between N_SRC requesters.
- A grant is held for a source from its first accepted word until its last-flagged word, so packets never interleave in the FIFO.
- Sits directly in front of the FIFO write port and drives its write enable and data from the FIFO's full flag.
- Optional idle timeout releases a grant held by a stalled source.

---
 rtl/sc_fifo_wr_arb_if.sv | 26 ++
 rtl/sc_fifo_wr_arb.sv | 118 +++++++++++
 tb/tb_sc_fifo_wr_arb.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sc_fifo_wr_arb_if.sv
// Handshake bundle between N_SRC packet sources and the write port of a
// single-clock FIFO, as seen by the sc_fifo_wr_arb write arbiter.
interface sc_fifo_wr_arb_if #(
  parameter int N_SRC  = 4,
  parameter int DATA_W = 256
);
  logic [N_SRC-1:0]        req_valid_i;
  logic [N_SRC*DATA_W-1:0] req_data_i;
  logic [N_SRC-1:0]        req_last_i;
  logic [N_SRC-1:0]        req_ready_o;
  logic                    fifo_full_i;
  logic                    fifo_wr_en_o;
  logic [DATA_W-1:0]       fifo_data_o;
  logic [N_SRC-1:0]        grant_o;
  logic                    tmo_o;

  modport master (
    output req_valid_i, req_data_i, req_last_i, fifo_full_i,
    input  req_ready_o, fifo_wr_en_o, fifo_data_o, grant_o, tmo_o
  );

  modport slave (
    input  req_valid_i, req_data_i, req_last_i, fifo_full_i,
    output req_ready_o, fifo_wr_en_o, fifo_data_o, grant_o, tmo_o
  );
endinterface

// File: rtl/sc_fifo_wr_arb.sv
// Round-robin, packet-locked write arbiter sharing one FIFO write port between
// N_SRC sources, with an optional idle timeout that releases a stalled grant.
module sc_fifo_wr_arb #(
  parameter int N_SRC   = 4,
  parameter int DATA_W  = 256,
  parameter int TMO_CYC = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  sc_fifo_wr_arb_if.slave bus
);
  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int TMO_W = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;

  typedef enum logic {ARB, XFER} state_e;

  state_e             state_q, state_d;
  logic [N_SRC-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;
  logic               sel_vld_q, sel_vld_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               tmo_q, tmo_d;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   cand;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ARB;
      grant_q   <= '0;
      rr_ptr_q  <= PTR_W'(N_SRC - 1);
      gidx_q    <= '0;
      sel_vld_q <= 1'b0;
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      gidx_q    <= gidx_d;
      sel_vld_q <= sel_vld_d;
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    gidx_d    = gidx_q;
    sel_vld_d = sel_vld_q;
    tmo_cnt_d = tmo_cnt_q;
    tmo_d     = 1'b0;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    unique case (state_q)
      ARB: begin
        // Search starts one past the last released source, wrapping around.
        for (int unsigned i = 1; i <= N_SRC; i++) begin
          cand = PTR_W'((32'(rr_ptr_q) + i) % N_SRC);
          if (!win_found && bus.req_valid_i[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
          end
        end
        if (win_found) begin
          state_d          = XFER;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          gidx_d           = win_idx;
          sel_vld_d        = 1'b1;
          tmo_cnt_d        = '0;
        end
      end
      XFER: begin
        if (bus.fifo_wr_en_o && bus.req_last_i[gidx_q]) begin
          state_d   = ARB;
          grant_d   = '0;
          rr_ptr_d  = gidx_q;
          tmo_cnt_d = '0;
        end else if (bus.req_valid_i[gidx_q]) begin
          tmo_cnt_d = '0;
        end else if (TMO_CYC > 0) begin
          if (tmo_cnt_q == TMO_W'(TMO_CYC - 1)) begin
            state_d   = ARB;
            grant_d   = '0;
            rr_ptr_d  = gidx_q;
            tmo_cnt_d = '0;
            tmo_d     = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
        end
      end
    endcase
  end

  // Write path is gated by rst_i so the reset cycle never issues a write.
  always_comb begin
    bus.req_ready_o  = '0;
    bus.fifo_wr_en_o = 1'b0;
    bus.fifo_data_o  = '0;
    if (sel_vld_q) begin
      bus.fifo_data_o = bus.req_data_i[32'(gidx_q) * DATA_W +: DATA_W];
    end
    if (state_q == XFER && !rst_i) begin
      bus.req_ready_o[gidx_q] = !bus.fifo_full_i;
      bus.fifo_wr_en_o        = bus.req_valid_i[gidx_q] & !bus.fifo_full_i;
    end
  end

  assign bus.grant_o = grant_q;
  assign bus.tmo_o   = tmo_q;
endmodule

// File: tb/tb_sc_fifo_wr_arb.sv
// Bench for sc_fifo_wr_arb: directed scenarios plus randomized packets checked
// against a packet-level round-robin model and a depth-4 FIFO occupancy model.
module tb_sc_fifo_wr_arb;
  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    vld;
  logic [N-1:0]    lst;
  logic [N*DW-1:0] dat;
  logic            full;
  int              cnt;
  int              tests;
  int              fails;

  always #5 clk = ~clk;

  sc_fifo_wr_arb_if #(.N_SRC(N), .DATA_W(DW)) bus_a ();
  sc_fifo_wr_arb_if #(.N_SRC(N), .DATA_W(DW)) bus_b ();

  assign bus_a.req_valid_i = vld;
  assign bus_a.req_data_i  = dat;
  assign bus_a.req_last_i  = lst;
  assign bus_a.fifo_full_i = full;
  assign bus_b.req_valid_i = vld;
  assign bus_b.req_data_i  = dat;
  assign bus_b.req_last_i  = lst;
  assign bus_b.fifo_full_i = full;

  sc_fifo_wr_arb #(.N_SRC(N), .DATA_W(DW), .TMO_CYC(0)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(bus_a)
  );
  sc_fifo_wr_arb #(.N_SRC(N), .DATA_W(DW), .TMO_CYC(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(bus_b)
  );

  // FIFO occupancy follows dut_a writes; full is a registered flag.
  task automatic tick(input bit pop);
    logic w;
    int   old;
    w   = bus_a.fifo_wr_en_o;
    old = cnt;
    @(posedge clk);
    #1;
    if (w) cnt++;
    if (pop && old > 0) cnt--;
    full = (cnt == DEPTH);
  endtask

  task automatic set_word(input int s, input logic [DW-1:0] w, input logic l);
    dat[s*DW +: DW] = w;
    lst[s]          = l;
  endtask

  task automatic do_reset();
    rst = 1'b1; vld = '0; lst = '0;
    tick(0);
    rst = 1'b0; cnt = 0; full = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = '0; lst = '0; dat = '0; cnt = 0; full = 1'b0;
    tick(0); tick(0);
    rst = 1'b0; cnt = 0; full = 1'b0;
    #1;
    tests++; if (bus_a.grant_o !== 4'b0000) begin fails++; $display("FAIL reset_grant: got %b want 0000", bus_a.grant_o); end
    tests++; if (bus_a.fifo_data_o !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", bus_a.fifo_data_o); end
    tests++; if (bus_a.tmo_o !== 1'b0 || bus_b.tmo_o !== 1'b0) begin fails++; $display("FAIL reset_tmo: got %b/%b want 0/0", bus_a.tmo_o, bus_b.tmo_o); end
    vld = 4'b1111; lst = 4'b1111; dat = 32'h33221100;
    #1;
    tests++; if (bus_a.req_ready_o !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %b want 0000", bus_a.req_ready_o); end
    tests++; if (bus_a.fifo_wr_en_o !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %b want 0", bus_a.fifo_wr_en_o); end
    tick(1);
    tests++; if (bus_a.grant_o !== 4'b0001) begin fails++; $display("FAIL reset_first_winner: got %b want 0001", bus_a.grant_o); end
    vld = '0;
  endtask

  task automatic test_single();
    logic [7:0] exp;
    do_reset();
    vld = 4'b0001; set_word(0, 8'hA0, 1'b0);
    #1;
    tests++; if (bus_a.grant_o !== 4'b0000 || bus_a.fifo_wr_en_o !== 1'b0) begin fails++; $display("FAIL single_arb: grant %b wr %b want 0000 0", bus_a.grant_o, bus_a.fifo_wr_en_o); end
    tick(1);
    for (int i = 0; i < 3; i++) begin
      exp = 8'(8'hA0 + i);
      set_word(0, exp, i == 2);
      #1;
      tests++; if (bus_a.grant_o !== 4'b0001 || bus_a.fifo_wr_en_o !== 1'b1 || bus_a.fifo_data_o !== exp) begin
        fails++; $display("FAIL single_word%0d: grant %b wr %b data %h want 0001 1 %h", i, bus_a.grant_o, bus_a.fifo_wr_en_o, bus_a.fifo_data_o, exp);
      end
      tick(1);
    end
    vld = '0; lst = '0;
    #1;
    tests++; if (bus_a.grant_o !== 4'b0000 || bus_a.fifo_wr_en_o !== 1'b0) begin fails++; $display("FAIL single_release: grant %b wr %b want 0000 0", bus_a.grant_o, bus_a.fifo_wr_en_o); end
    vld = 4'b0011; set_word(0, 8'hA3, 1'b1); set_word(1, 8'h50, 1'b1);
    tick(1);
    tests++; if (bus_a.grant_o !== 4'b0010) begin fails++; $display("FAIL single_rr_ptr: got %b want 0010", bus_a.grant_o); end
    vld = '0;
  endtask

  task automatic test_round_robin();
    int rem[N]  = '{4, 2, 2, 2};
    int sent[N] = '{0, 0, 0, 0};
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    int order[$];
    logic [7:0] expq[$];
    logic [7:0] e;
    logic [N-1:0] prev_g, acc;
    int idle, cyc, g;
    do_reset();
    for (int k = 0; k < 2; k++) expq.push_back(8'(k));
    for (int s = 1; s < N; s++) for (int k = 0; k < 2; k++) expq.push_back(8'(s * 64 + k));
    for (int k = 2; k < 4; k++) expq.push_back(8'(k));
    prev_g = '0; idle = 0; cyc = 0;
    while (expq.size() > 0 && cyc < 60) begin
      for (int s = 0; s < N; s++) begin
        vld[s] = rem[s] > 0;
        set_word(s, 8'(s * 64 + sent[s]), sent[s] % 2 == 1);
      end
      #1;
      if (bus_a.grant_o !== '0 && prev_g === '0) begin
        g = -1;
        for (int s = 0; s < N; s++) if (bus_a.grant_o[s]) g = s;
        order.push_back(g);
      end
      if (bus_a.grant_o === '0 && order.size() > 0) idle++;
      if (bus_a.fifo_wr_en_o === 1'b1) begin
        e = expq.pop_front();
        tests++; if (bus_a.fifo_data_o !== e) begin fails++; $display("FAIL rr_data: got %h want %h", bus_a.fifo_data_o, e); end
      end
      acc = vld & bus_a.req_ready_o;
      for (int s = 0; s < N; s++) if (acc[s]) begin sent[s]++; rem[s]--; end
      prev_g = bus_a.grant_o;
      cyc++;
      tick(1);
    end
    for (int i = 0; i < 5; i++) begin
      g = (i < order.size()) ? order[i] : -1;
      tests++; if (g != exp_ord[i]) begin fails++; $display("FAIL rr_order%0d: got %0d want %0d", i, g, exp_ord[i]); end
    end
    tests++; if (idle != 4) begin fails++; $display("FAIL rr_bubbles: got %0d want 4", idle); end
    tests++; if (cyc != 15) begin fails++; $display("FAIL rr_cycles: got %0d want 15", cyc); end
    vld = '0;
  endtask

  task automatic test_full_stall();
    int sent, nwr, bad;
    do_reset();
    sent = 0; nwr = 0; bad = 0;
    for (int cyc = 0; cyc < 18; cyc++) begin
      vld[2] = sent < 6;
      set_word(2, 8'(8'h80 + sent), sent == 5);
      #1;
      if (full && (bus_a.fifo_wr_en_o !== 1'b0 || bus_a.req_ready_o[2] !== 1'b0)) bad++;
      if (bus_a.fifo_wr_en_o === 1'b1) begin
        tests++; if (bus_a.fifo_data_o !== 8'(8'h80 + nwr)) begin fails++; $display("FAIL full_data%0d: got %h want %h", nwr, bus_a.fifo_data_o, 8'(8'h80 + nwr)); end
        nwr++;
      end
      if (vld[2] && bus_a.req_ready_o[2]) sent++;
      if (cyc == 9) begin
        tests++; if (nwr != 4 || full !== 1'b1) begin fails++; $display("FAIL full_fill: writes %0d full %b want 4 1", nwr, full); end
      end
      tick(cyc == 10 || cyc == 11);
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL full_no_write: got %0d violations want 0", bad); end
    tests++; if (nwr != 6) begin fails++; $display("FAIL full_total: got %0d writes want 6", nwr); end
    tests++; if (bus_a.grant_o !== 4'b0000) begin fails++; $display("FAIL full_release: got %b want 0000", bus_a.grant_o); end
    vld = '0;
  endtask

  task automatic test_non_interleave();
    logic [N-1:0] waiters, want;
    int sent, gap, cyc;
    for (int sc = 0; sc < 2; sc++) begin
      waiters = (sc == 0) ? 4'b0001 : 4'b1001;
      want    = (sc == 0) ? 4'b0001 : 4'b1000;
      do_reset();
      vld = 4'b0010; set_word(1, 8'h40, 1'b0);
      #1;
      tick(1);
      vld = 4'b0010 | waiters; set_word(0, 8'h00, 1'b1); set_word(3, 8'hC0, 1'b1);
      sent = 0; gap = 0; cyc = 0;
      while (sent < 4 && cyc < 20) begin
        if (sent == 2 && gap < 2) begin vld[1] = 1'b0; gap++; end
        else vld[1] = 1'b1;
        set_word(1, 8'(8'h40 + sent), sent == 3);
        #1;
        tests++; if (bus_a.grant_o !== 4'b0010) begin fails++; $display("FAIL ni%0d_hold: got %b want 0010", sc, bus_a.grant_o); end
        if (bus_a.fifo_wr_en_o === 1'b1) begin
          tests++; if (bus_a.fifo_data_o !== 8'(8'h40 + sent)) begin fails++; $display("FAIL ni%0d_data: got %h want %h", sc, bus_a.fifo_data_o, 8'(8'h40 + sent)); end
        end
        if (vld[1] && bus_a.req_ready_o[1]) sent++;
        cyc++;
        tick(1);
      end
      vld[1] = 1'b0;
      #1;
      tests++; if (sent != 4 || bus_a.grant_o !== 4'b0000) begin fails++; $display("FAIL ni%0d_done: sent %0d grant %b want 4 0000", sc, sent, bus_a.grant_o); end
      tick(1);
      tests++; if (bus_a.grant_o !== want) begin fails++; $display("FAIL ni%0d_next: got %b want %b", sc, bus_a.grant_o, want); end
    end
    vld = '0;
  endtask

  task automatic test_timeout();
    int bad;
    do_reset();
    vld = 4'b1000; set_word(3, 8'hC0, 1'b0);
    #1;
    tick(1);
    #1;
    tests++; if (bus_b.grant_o !== 4'b1000 || bus_b.fifo_wr_en_o !== 1'b1) begin fails++; $display("FAIL tmo_word: grant %b wr %b want 1000 1", bus_b.grant_o, bus_b.fifo_wr_en_o); end
    tick(1);
    vld = 4'b0001; set_word(0, 8'h00, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++; if (bus_b.tmo_o !== 1'b0 || bus_b.grant_o !== 4'b1000) begin fails++; $display("FAIL tmo_wait%0d: tmo %b grant %b want 0 1000", k, bus_b.tmo_o, bus_b.grant_o); end
      tick(1);
    end
    #1;
    tests++; if (bus_b.tmo_o !== 1'b1 || bus_b.grant_o !== 4'b0000) begin fails++; $display("FAIL tmo_pulse: tmo %b grant %b want 1 0000", bus_b.tmo_o, bus_b.grant_o); end
    tick(1);
    tests++; if (bus_b.tmo_o !== 1'b0 || bus_b.grant_o !== 4'b0001) begin fails++; $display("FAIL tmo_regrant: tmo %b grant %b want 0 0001", bus_b.tmo_o, bus_b.grant_o); end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus_a.tmo_o !== 1'b0 || bus_a.grant_o !== 4'b1000) bad++;
      tick(1);
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL tmo_disabled_hold: got %0d violations want 0", bad); end
    vld = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    vld = 4'b0010; set_word(1, 8'h40, 1'b0);
    #1;
    tick(1);
    tests++; if (bus_a.fifo_wr_en_o !== 1'b1) begin fails++; $display("FAIL rmid_word1: wr %b want 1", bus_a.fifo_wr_en_o); end
    tick(1);
    rst = 1'b1; vld = 4'b0011; set_word(1, 8'h41, 1'b0); set_word(0, 8'h00, 1'b1);
    #1;
    tests++; if (bus_a.fifo_wr_en_o !== 1'b0 || bus_a.req_ready_o !== 4'b0000) begin fails++; $display("FAIL rmid_rst_cycle: wr %b ready %b want 0 0000", bus_a.fifo_wr_en_o, bus_a.req_ready_o); end
    tick(1);
    rst = 1'b0;
    #1;
    tests++; if (bus_a.grant_o !== 4'b0000 || bus_a.fifo_wr_en_o !== 1'b0 || bus_a.req_ready_o !== 4'b0000) begin
      fails++; $display("FAIL rmid_after: grant %b wr %b ready %b want 0000 0 0000", bus_a.grant_o, bus_a.fifo_wr_en_o, bus_a.req_ready_o);
    end
    tick(1);
    tests++; if (bus_a.grant_o !== 4'b0001) begin fails++; $display("FAIL rmid_winner: got %b want 0001", bus_a.grant_o); end
    vld = '0;
  endtask

  task automatic test_random();
    logic [7:0] words[N][$];
    bit         lasts[N][$];
    int         plens[N][$];
    logic [7:0] expq[$];
    logic [7:0] e;
    int idx[N], dly[N], pk[N], pos[N];
    int npk, len, ptr, pick, cyc, bad;
    logic [N-1:0] acc;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int s = 0; s < N; s++) begin
        words[s].delete(); lasts[s].delete(); plens[s].delete();
        idx[s] = 0; dly[s] = 0; pk[s] = 0; pos[s] = 0;
        npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++) begin
          len = $urandom_range(1, 5);
          plens[s].push_back(len);
          for (int w = 0; w < len; w++) begin
            words[s].push_back(8'(s * 64 + words[s].size()));
            lasts[s].push_back(w == len - 1);
          end
        end
      end
      // Whole packets leave in round-robin order among sources with work left.
      expq.delete();
      ptr = N - 1;
      forever begin
        pick = -1;
        for (int i = 1; i <= N; i++)
          if (pick < 0 && pk[(ptr + i) % N] < plens[(ptr + i) % N].size()) pick = (ptr + i) % N;
        if (pick < 0) break;
        for (int w = 0; w < plens[pick][pk[pick]]; w++) expq.push_back(words[pick][pos[pick] + w]);
        pos[pick] += plens[pick][pk[pick]];
        pk[pick]++;
        ptr = pick;
      end
      cyc = 0; bad = 0;
      while (expq.size() > 0 && cyc < 1500) begin
        for (int s = 0; s < N; s++) begin
          vld[s] = (idx[s] < words[s].size()) && dly[s] == 0;
          if (idx[s] < words[s].size()) set_word(s, words[s][idx[s]], lasts[s][idx[s]]);
        end
        #1;
        if (full && bus_a.fifo_wr_en_o !== 1'b0) bad++;
        if (!$onehot0(bus_a.grant_o) || (bus_a.req_ready_o & ~bus_a.grant_o) !== '0) bad++;
        if (bus_a.fifo_wr_en_o === 1'b1) begin
          e = expq.pop_front();
          tests++; if (bus_a.fifo_data_o !== e) begin fails++; $display("FAIL rand%0d_data: got %h want %h", r, bus_a.fifo_data_o, e); end
        end
        acc = vld & bus_a.req_ready_o;
        for (int s = 0; s < N; s++) begin
          if (acc[s]) begin
            idx[s]++;
            dly[s] = (idx[s] < words[s].size() && !lasts[s][idx[s] - 1]) ? int'($urandom_range(0, 2)) : 0;
          end else if (dly[s] > 0) begin
            dly[s]--;
          end
        end
        cyc++;
        tick($urandom_range(0, 1) == 1);
      end
      tests++; if (expq.size() != 0) begin fails++; $display("FAIL rand%0d_drain: %0d words not written within budget", r, expq.size()); end
      tests++; if (bad != 0) begin fails++; $display("FAIL rand%0d_rules: got %0d violations want 0", r, bad); end
      vld = '0;
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; vld = '0; lst = '0; dat = '0; full = 1'b0; cnt = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_non_interleave();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
